// File: rtl/semafor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : semafor_pkg                                                      |
// | Brief   : State encodings, light codes and timing defaults for the car     |
// |           signal controller at the pedestrian crossing.                    |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package semafor_pkg;

    localparam logic [23:0] C_SEC_DEFAULT = 24'd10000000;

    typedef enum logic [2:0] {
        S_VERDE       = 3'd0,
        S_GALBEN      = 3'd1,
        S_ROSU_PRE    = 3'd2,
        S_PIETONI     = 3'd3,
        S_ROSU_GALBEN = 3'd4,
        S_INTRETINERE = 3'd5
    } state_t;

    // Light codes are {rosu, galben, verde}.
    localparam logic [2:0] C_LIGHT_VERDE       = 3'b001;
    localparam logic [2:0] C_LIGHT_GALBEN      = 3'b010;
    localparam logic [2:0] C_LIGHT_ROSU        = 3'b100;
    localparam logic [2:0] C_LIGHT_ROSU_GALBEN = 3'b110;

    function automatic logic [2:0] light_code(input state_t st, input logic blink);
        case (st)
            S_VERDE:       return C_LIGHT_VERDE;
            S_GALBEN:      return C_LIGHT_GALBEN;
            S_ROSU_GALBEN: return C_LIGHT_ROSU_GALBEN;
            S_INTRETINERE: return {1'b0, blink, 1'b0};
            default:       return C_LIGHT_ROSU;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/semafor_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : semafor_tick_gen                                                 |
// | Brief   : Prescaler with synchronous clear giving 1 s and half-second      |
// |           ticks; shared with the pedestrian signal module.                 |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module semafor_tick_gen
    import semafor_pkg::*;
#(
    parameter logic [23:0] SEC = C_SEC_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick_1s,
    output logic tick_half
);

    localparam logic [23:0] C_LAST = SEC - 24'd1;
    localparam logic [23:0] C_HALF = (SEC >> 1) - 24'd1;

    logic [23:0] r_presc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (clr || (r_presc == C_LAST)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 24'd1;
        end
    end

    assign tick_1s   = (r_presc == C_LAST);
    assign tick_half = (r_presc == C_HALF) || tick_1s;

endmodule
`default_nettype wire

// File: rtl/semafor_intersectie_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : semafor_intersectie_ctrl                                         |
// | Brief   : Car signal controller sequencing the pedestrian module, with     |
// |           maintenance blink and pedestrian-phase watchdog.                 |
// |           Optional: SEMAFOR_PED_COUNT_EN adds ped_count_o.                 |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module semafor_intersectie_ctrl
    import semafor_pkg::*;
#(
    parameter logic [23:0] SEC           = C_SEC_DEFAULT,
    parameter int          T_MIN_VERDE   = 8,
    parameter int          T_GALBEN      = 3,
    parameter int          T_ROSU_PRE    = 1,
    parameter int          T_ROSU_GALBEN = 2,
    parameter int          PED_TIMEOUT   = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        intretinere,
    input  logic        buton_pietoni,
    input  logic        pietoni_stop,
    output logic        pietoni_start,
    output logic        rosu_o,
    output logic        galben_o,
    output logic        verde_o,
    output logic        cerere_o,
    output logic        fault_o
`ifdef SEMAFOR_PED_COUNT_EN
    ,
    output logic [15:0] ped_count_o
`endif
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_state_chg;
    logic       w_enter_ped;
    logic       w_tick_1s;
    logic       w_tick_half;
    logic [7:0] r_sec_cnt;
    logic [8:0] w_secs_next;
    logic       r_first;
    logic       r_btn_s1;
    logic       r_btn_s2;
    logic       r_btn_prev;
    logic       w_btn_edge;
    logic       r_cerere;
    logic       r_fault;
    logic       r_start;
    logic       r_blink;
    logic [2:0] r_lights;
    logic       w_ped_stop;
    logic       w_ped_timeout;

    semafor_tick_gen #(
        .SEC       (SEC)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .clr       (w_state_chg),
        .tick_1s   (w_tick_1s),
        .tick_half (w_tick_half)
    );

    assign w_state_chg = (w_state_next != r_state);
    assign w_enter_ped = (w_state_next == S_PIETONI) && (r_state != S_PIETONI);
    assign w_secs_next = {1'b0, r_sec_cnt} + 9'd1;
    assign w_btn_edge  = r_btn_s2 && !r_btn_prev;

    // The done level is ignored on the start-pulse cycle: the pedestrian module
    // may still be reporting its previous phase.
    assign w_ped_stop    = (r_state == S_PIETONI) && !r_first && pietoni_stop;
    assign w_ped_timeout = (r_state == S_PIETONI) && !w_ped_stop && w_tick_1s
                           && (w_secs_next >= 9'(PED_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_ROSU_GALBEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_VERDE: begin
                if (intretinere) begin
                    w_state_next = S_INTRETINERE;
                end else if (r_cerere && w_tick_1s && (w_secs_next >= 9'(T_MIN_VERDE))) begin
                    w_state_next = S_GALBEN;
                end
            end
            S_GALBEN: begin
                if (intretinere) begin
                    w_state_next = S_INTRETINERE;
                end else if (w_tick_1s && (w_secs_next >= 9'(T_GALBEN))) begin
                    w_state_next = S_ROSU_PRE;
                end
            end
            S_ROSU_PRE: begin
                if (intretinere) begin
                    w_state_next = S_INTRETINERE;
                end else if (w_tick_1s && (w_secs_next >= 9'(T_ROSU_PRE))) begin
                    w_state_next = S_PIETONI;
                end
            end
            S_PIETONI: begin
                if (w_ped_stop || w_ped_timeout) begin
                    w_state_next = intretinere ? S_INTRETINERE : S_ROSU_GALBEN;
                end
            end
            S_ROSU_GALBEN: begin
                if (intretinere) begin
                    w_state_next = S_INTRETINERE;
                end else if (w_tick_1s && (w_secs_next >= 9'(T_ROSU_GALBEN))) begin
                    w_state_next = S_VERDE;
                end
            end
            S_INTRETINERE: begin
                if (!intretinere) begin
                    w_state_next = S_ROSU_GALBEN;
                end
            end
            default: begin
                w_state_next = S_ROSU_GALBEN;
            end
        endcase
    end

    // Seconds counter saturates so a long idle green never wraps below the minimum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sec_cnt <= '0;
            r_first   <= 1'b1;
        end else begin
            r_first <= w_state_chg;
            if (w_state_chg) begin
                r_sec_cnt <= '0;
            end else if (w_tick_1s && (r_sec_cnt != 8'hFF)) begin
                r_sec_cnt <= r_sec_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_btn_prev <= 1'b0;
            r_cerere   <= 1'b0;
        end else begin
            r_btn_s1   <= buton_pietoni;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
            if (w_enter_ped) begin
                r_cerere <= 1'b0;
            end else if (w_btn_edge) begin
                r_cerere <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fault  <= 1'b0;
            r_start  <= 1'b0;
            r_blink  <= 1'b1;
            r_lights <= C_LIGHT_ROSU;
        end else begin
            r_fault  <= r_fault || w_ped_timeout;
            r_start  <= w_enter_ped;
            r_lights <= light_code(r_state, r_blink);
            if (w_state_chg) begin
                r_blink <= 1'b1;
            end else if ((r_state == S_INTRETINERE) && w_tick_half) begin
                r_blink <= ~r_blink;
            end
        end
    end

    assign {rosu_o, galben_o, verde_o} = r_lights;
    assign pietoni_start = r_start;
    assign cerere_o      = r_cerere;
    assign fault_o       = r_fault;

`ifdef SEMAFOR_PED_COUNT_EN
    logic [15:0] r_ped_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ped_count <= '0;
        end else if (w_ped_stop && (r_ped_count != 16'hFFFF)) begin
            r_ped_count <= r_ped_count + 16'd1;
        end
    end

    assign ped_count_o = r_ped_count;
`endif

endmodule
`default_nettype wire

// File: doc/semafor_intersectie_ctrl.md
Name: semafor_intersectie_ctrl

Overview:
Controller for a single-lane vehicle signal at a pedestrian crossing. It owns the car lights (red/yellow/green) and sequences the pedestrian signal module through a start/stop handshake: one-cycle start pulse out, level "done" in. It also handles the maintenance mode (flashing yellow) and a watchdog on the pedestrian phase.

Parameters:
SEC, 24'd10000000, clk cycles per second (benches use SEC=10)
T_MIN_VERDE, 8, minimum car-green seconds before serving a pending pedestrian request
T_GALBEN, 3, car-yellow seconds
T_ROSU_PRE, 1, all-red clearance seconds before pedestrian start
T_ROSU_GALBEN, 2, red+yellow seconds before car green
PED_TIMEOUT, 30, max seconds to wait for pietoni_stop

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
intretinere  in  1  maintenance request, level, synchronous to clk
buton_pietoni  in  1  pedestrian push-button, asynchronous
pietoni_stop  in  1  pedestrian module done, level
pietoni_start  out  1  one-clk pulse that starts the pedestrian module
rosu_o  out  1  car red
galben_o  out  1  car yellow
verde_o  out  1  car green
cerere_o  out  1  pedestrian request pending ("wait" lamp)
fault_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async, active-low): state=S_ROSU_GALBEN. rosu_o=1, galben_o=0, verde_o=0, pietoni_start=0, cerere_o=0, fault_o=0. Prescaler, second counter and button synchroniser are cleared.
- Tick generator: prescaler counts 0..SEC-1. tick_1s=1 when it equals SEC-1. tick_half=1 when it equals SEC/2-1 or SEC-1. Prescaler and sec_cnt (8-bit) clear synchronously on every state change, so a state lasting T seconds occupies exactly T*SEC cycles.
- Button: 2-FF synchroniser, then rising-edge detect; the edge sets cerere. cerere clears on the cycle of entry into S_PIETONI, and the clear beats a same-cycle set. An edge on any later cycle sets cerere again and it is served next round. A held button produces a single request.
- FSM (state register async-reset, next-state logic combinational):
  S_VERDE: stay while !cerere. Go to S_GALBEN on the tick_1s at which cerere && sec_cnt+1>=T_MIN_VERDE.
  S_GALBEN: go to S_ROSU_PRE after T_GALBEN s.
  S_ROSU_PRE: go to S_PIETONI after T_ROSU_PRE s.
  S_PIETONI: pietoni_start=1 on the first cycle only. From the 2nd cycle, go to S_ROSU_GALBEN when pietoni_stop=1. If sec_cnt reaches PED_TIMEOUT, set fault_o and go to S_ROSU_GALBEN.
  S_ROSU_GALBEN: go to S_VERDE after T_ROSU_GALBEN s.
  S_INTRETINERE: galben_o toggles on every tick_half, starting at 1. Go to S_ROSU_GALBEN when intretinere=0.
- Maintenance: intretinere=1 forces S_INTRETINERE on the next clock from any state except S_PIETONI. In S_PIETONI the transition is deferred until pietoni_stop or the timeout fires, then goes directly to S_INTRETINERE. cerere is preserved across maintenance.
- Lights are registered from the current state, so there is 1 clk latency after a state change:
  - VERDE: 001
  - GALBEN: 010
  - ROSU_PRE and PIETONI: 100
  - ROSU_GALBEN: 110
  - INTRETINERE: 0,blink,0
  - (bits are rosu, galben, verde)
- cerere_o mirrors cerere, registered.
- fault_o clears only on reset.
- Invariant: verde_o=1 never coincides with rosu_o=1 or galben_o=1.
- Reset mid-phase: everything returns to reset values immediately. The pedestrian module is reset by the same net.

Optional Feature:
SEMAFOR_PED_COUNT_EN:
- Defined: adds port ped_count_o out 16, which counts completed pedestrian phases (S_PIETONI exits via pietoni_stop, not timeout). It saturates at 16'hFFFF and resets to 0.
- Undefined: no port and no counter logic.

Decomposition:
- semafor_pkg holds:
  - state encodings (3-bit localparams S_VERDE..S_INTRETINERE)
  - light-code constants
  - the SEC default
- Sub-module semafor_tick_gen holds the prescaler with synchronous clear input and the tick_1s/tick_half outputs. It is reused by the pedestrian module.

Test Plan:
- Reset release, no button (SEC=10): lights 110 for 20 clks, then 001 held indefinitely; pietoni_start never pulses.
- Button pressed at 3 s into green: green lasts 80 clks total, then 010 for 30, 100 for 10, one pietoni_start pulse. pietoni_stop at +50 clks, then 110 for 20, then 001; cerere_o is 0 from the start pulse onward.
- Button pressed at 15 s into green: leaves green on the next tick_1s, with yellow beginning 1 clk after it.
- pietoni_stop held low: after 300 clks in S_PIETONI, fault_o=1 and the sequence continues to 110. fault_o stays 1 until reset.
- intretinere=1 during S_PIETONI: no change until pietoni_stop. Then galben_o toggles every 5 clks with rosu/verde at 0. Dropping intretinere gives 110 for 20 clks, then green.
- Button pulses on the S_PIETONI entry cycle and at +2 clks: first is ignored, second is latched, so cerere_o=1 after the phase. Async reset mid-yellow gives 100 immediately.
